// File: rtl/ps2_kbd_matrix.sv
// PS/2 set-2 keyboard front end: filtered receiver, make/break decoder and an
// 8x8 key matrix read back through an active-high row select.
module ps2_kbd_matrix #(
    parameter int FILT_LEN = 16,
    parameter int FRAME_TO = 100000
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic [7:0] addr,
    output logic [7:0] odata,
    output logic [2:0] shift,
    output logic [2:0] reset_key
);
    localparam int FW  = $clog2(FILT_LEN + 1);
    localparam int TOW = $clog2(FRAME_TO + 1);
    localparam logic [1:0] K_NONE = 2'd0, K_MAT = 2'd1, K_SHF = 2'd2, K_RST = 2'd3;

    logic [1:0] w_raw;
    logic [1:0] w_filt;
    assign w_raw = {ps2_dat, ps2_clk};

    // Both lines idle high, so the synchronisers and filters come out of reset high
    // and a line held low after reset produces a genuine edge.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_filt
            logic          r_s1, r_s2, r_lvl;
            logic [FW-1:0] r_cnt;
            always_ff @(posedge clk_sys) begin
                if (reset) begin
                    r_s1  <= 1'b1;
                    r_s2  <= 1'b1;
                    r_lvl <= 1'b1;
                    r_cnt <= '0;
                end else begin
                    r_s1 <= w_raw[gi];
                    r_s2 <= r_s1;
                    if (r_s2 == r_lvl) begin
                        r_cnt <= '0;
                    end else if (r_cnt == FW'(FILT_LEN - 1)) begin
                        r_lvl <= r_s2;
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end
            assign w_filt[gi] = r_lvl;
        end
    endgenerate

    logic           r_clk_prev;
    logic [3:0]     r_bit_cnt;
    logic [7:0]     r_rx_sr;
    logic           r_par;
    logic [TOW-1:0] r_to_cnt;
    logic [7:0]     r_byte;
    logic           r_byte_stb;
    logic           w_fall;

    assign w_fall = r_clk_prev & ~w_filt[0];

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_clk_prev <= 1'b1;
            r_bit_cnt  <= '0;
            r_rx_sr    <= '0;
            r_par      <= 1'b0;
            r_to_cnt   <= '0;
            r_byte     <= '0;
            r_byte_stb <= 1'b0;
        end else begin
            r_clk_prev <= w_filt[0];
            r_byte_stb <= 1'b0;
            if (w_fall) begin
                r_to_cnt <= '0;
                if (r_bit_cnt == 4'd0) begin
                    if (!w_filt[1])
                        r_bit_cnt <= 4'd1;
                end else if (r_bit_cnt <= 4'd8) begin
                    r_rx_sr   <= {w_filt[1], r_rx_sr[7:1]};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end else if (r_bit_cnt == 4'd9) begin
                    r_par     <= w_filt[1];
                    r_bit_cnt <= 4'd10;
                end else begin
                    // Stop bit: accept only with odd parity over data+parity and stop high.
                    if (w_filt[1] && (^{r_rx_sr, r_par})) begin
                        r_byte     <= r_rx_sr;
                        r_byte_stb <= 1'b1;
                    end
                    r_bit_cnt <= 4'd0;
                end
            end else if (r_bit_cnt != 4'd0) begin
                if (r_to_cnt == TOW'(FRAME_TO - 1)) begin
                    r_bit_cnt <= 4'd0;
                    r_to_cnt  <= '0;
                end else begin
                    r_to_cnt <= r_to_cnt + 1'b1;
                end
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    function automatic logic [7:0] m(input logic [2:0] row, input logic [2:0] col);
        return {K_MAT, row, col};
    endfunction

    // Returns {kind, row, col}; for shift/reset_key kinds the low bits give the bit index.
    function automatic logic [7:0] lookup(input logic ext, input logic [7:0] code);
        logic [7:0] res;
        res = {K_NONE, 6'd0};
        case ({ext, code})
            9'h00D: res = m(0, 0);  9'h05A: res = m(0, 2);  9'h066: res = m(0, 3);
            9'h16B: res = m(0, 4);  9'h175: res = m(0, 5);  9'h174: res = m(0, 6);
            9'h172: res = m(0, 7);
            9'h16C: res = m(1, 0);  9'h076: res = m(1, 1);  9'h005: res = m(1, 3);
            9'h006: res = m(1, 4);  9'h004: res = m(1, 5);  9'h00C: res = m(1, 6);
            9'h003: res = m(1, 7);
            9'h045: res = m(2, 0);  9'h016: res = m(2, 1);  9'h01E: res = m(2, 2);
            9'h026: res = m(2, 3);  9'h025: res = m(2, 4);  9'h02E: res = m(2, 5);
            9'h036: res = m(2, 6);  9'h03D: res = m(2, 7);
            9'h03E: res = m(3, 0);  9'h046: res = m(3, 1);  9'h04C: res = m(3, 2);
            9'h04E: res = m(3, 3);  9'h041: res = m(3, 4);  9'h055: res = m(3, 5);
            9'h049: res = m(3, 6);  9'h04A: res = m(3, 7);
            9'h00E: res = m(4, 0);  9'h01C: res = m(4, 1);  9'h032: res = m(4, 2);
            9'h021: res = m(4, 3);  9'h023: res = m(4, 4);  9'h024: res = m(4, 5);
            9'h02B: res = m(4, 6);  9'h034: res = m(4, 7);
            9'h033: res = m(5, 0);  9'h043: res = m(5, 1);  9'h03B: res = m(5, 2);
            9'h042: res = m(5, 3);  9'h04B: res = m(5, 4);  9'h03A: res = m(5, 5);
            9'h031: res = m(5, 6);  9'h044: res = m(5, 7);
            9'h04D: res = m(6, 0);  9'h015: res = m(6, 1);  9'h02D: res = m(6, 2);
            9'h01B: res = m(6, 3);  9'h02C: res = m(6, 4);  9'h03C: res = m(6, 5);
            9'h02A: res = m(6, 6);  9'h01D: res = m(6, 7);
            9'h022: res = m(7, 0);  9'h035: res = m(7, 1);  9'h01A: res = m(7, 2);
            9'h054: res = m(7, 3);  9'h05D: res = m(7, 4);  9'h05B: res = m(7, 5);
            9'h052: res = m(7, 6);  9'h029: res = m(7, 7);
            9'h012, 9'h059: res = {K_SHF, 6'd0};
            9'h014, 9'h114: res = {K_SHF, 6'd1};
            9'h058:         res = {K_SHF, 6'd2};
            9'h078:         res = {K_RST, 6'd0};
            9'h007:         res = {K_RST, 6'd1};
            9'h011, 9'h111: res = {K_RST, 6'd2};
            default:        res = {K_NONE, 6'd0};
        endcase
        return res;
    endfunction

    logic [63:0] r_matrix;
    logic [2:0]  r_shift;
    logic [2:0]  r_rkey;
    logic        r_ext;
    logic        r_brk;
    logic [2:0]  r_skip;
    logic [7:0]  w_lut;

    assign w_lut = lookup(r_ext, r_byte);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_matrix <= '0;
            r_shift  <= '0;
            r_rkey   <= '0;
            r_ext    <= 1'b0;
            r_brk    <= 1'b0;
            r_skip   <= '0;
        end else if (r_byte_stb) begin
            if (r_skip != 3'd0) begin
                r_skip <= r_skip - 3'd1;
            end else if (r_byte == 8'hE0) begin
                r_ext <= 1'b1;
            end else if (r_byte == 8'hF0) begin
                r_brk <= 1'b1;
            end else if (r_byte == 8'hE1) begin
                r_skip <= 3'd7;
            end else begin
                case (w_lut[7:6])
                    K_MAT:   r_matrix[w_lut[5:0]] <= ~r_brk;
                    K_SHF:   r_shift[w_lut[1:0]]  <= ~r_brk;
                    K_RST:   r_rkey[w_lut[1:0]]   <= ~r_brk;
                    default: ;
                endcase
                r_ext <= 1'b0;
                r_brk <= 1'b0;
            end
        end
    end

    logic [7:0] w_row [8];
    logic [7:0] w_or;
    logic [7:0] r_odata;

    generate
        for (gi = 0; gi < 8; gi++) begin : g_row
            assign w_row[gi] = addr[gi] ? r_matrix[gi*8 +: 8] : 8'h00;
        end
    endgenerate

    always_comb begin
        w_or = 8'h00;
        for (int i = 0; i < 8; i++)
            w_or = w_or | w_row[i];
    end

    always_ff @(posedge clk_sys) begin
        if (reset)
            r_odata <= 8'h00;
        else
            r_odata <= w_or;
    end

    assign odata     = r_odata;
    assign shift     = r_shift;
    assign reset_key = r_rkey;
endmodule

// File: tb/tb_ps2_kbd_matrix.sv
// Directed bench for ps2_kbd_matrix: drives PS/2 frames bit by bit and checks the
// matrix readback, modifier bits and error/timeout recovery against hand values.
module tb_ps2_kbd_matrix;
    localparam int HP   = 30;    // half period of the PS/2 clock in clk_sys cycles
    localparam int IDLE = 60;
    localparam int TO   = 1000;

    logic       clk_sys = 1'b0;
    logic       reset   = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] addr    = 8'h00;
    logic [7:0] odata;
    logic [2:0] shift;
    logic [2:0] reset_key;

    int n_vec = 0;
    int n_err = 0;

    ps2_kbd_matrix #(.FILT_LEN(16), .FRAME_TO(TO)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .addr      (addr),
        .odata     (odata),
        .shift     (shift),
        .reset_key (reset_key)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic cycles(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic send_bits(input logic [10:0] frame, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            ps2_dat = frame[i];
            cycles(HP);
            ps2_clk = 1'b0;
            cycles(HP);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        logic par;
        par = ~(^b) ^ bad_par;
        send_bits({1'b1, par, b, 1'b0}, 11);
        cycles(IDLE);
    endtask

    task automatic key(input logic [7:0] b);
        send_byte(b, 1'b0);
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        addr = 8'hFF;
        cycles(3);
        if (odata !== 8'h00) begin $display("FAIL reset_odata got=%02h want=00", odata); n_err++; end
        n_vec++;
        if (shift !== 3'b000) begin $display("FAIL reset_shift got=%b want=000", shift); n_err++; end
        n_vec++;
        if (reset_key !== 3'b000) begin $display("FAIL reset_key got=%b want=000", reset_key); n_err++; end
        n_vec++;
    endtask

    task automatic test_make_break();
        addr = 8'h10;
        key(8'h1C);
        if (odata !== 8'h02) begin $display("FAIL make_A got=%02h want=02", odata); n_err++; end
        n_vec++;
        addr = 8'h00;
        cycles(2);
        if (odata !== 8'h00) begin $display("FAIL addr_zero got=%02h want=00", odata); n_err++; end
        n_vec++;
        addr = 8'h10;
        key(8'hF0); key(8'h1C);
        if (odata !== 8'h00) begin $display("FAIL break_A got=%02h want=00", odata); n_err++; end
        n_vec++;
        $display("make/break A done: odata=%02h", odata);
    endtask

    task automatic test_extended();
        addr = 8'h01;
        key(8'hE0); key(8'h75);
        if (odata !== 8'h20) begin $display("FAIL ext_up got=%02h want=20", odata); n_err++; end
        n_vec++;
        addr = 8'hFF;
        key(8'h75);
        if (odata !== 8'h20) begin $display("FAIL kp8_nochange got=%02h want=20", odata); n_err++; end
        n_vec++;
        key(8'hE0); key(8'hF0); key(8'h75);
        if (odata !== 8'h00) begin $display("FAIL ext_up_break got=%02h want=00", odata); n_err++; end
        n_vec++;
        $display("extended Up done: odata=%02h", odata);
    endtask

    task automatic test_parity();
        addr = 8'h10;
        send_byte(8'h1C, 1'b1);
        if (odata !== 8'h00) begin $display("FAIL bad_parity got=%02h want=00", odata); n_err++; end
        n_vec++;
        key(8'h1C);
        if (odata !== 8'h02) begin $display("FAIL after_bad_parity got=%02h want=02", odata); n_err++; end
        n_vec++;
        key(8'hF0); key(8'h1C);
        $display("parity recovery done: odata=%02h", odata);
    endtask

    task automatic test_modifiers();
        key(8'h12); key(8'h14); key(8'h11); key(8'h78);
        if (shift !== 3'b011) begin $display("FAIL mod_shift got=%b want=011", shift); n_err++; end
        n_vec++;
        if (reset_key !== 3'b101) begin $display("FAIL mod_rkey got=%b want=101", reset_key); n_err++; end
        n_vec++;
        key(8'hF0); key(8'h12); key(8'hF0); key(8'h14);
        key(8'hF0); key(8'h11); key(8'hF0); key(8'h78);
        if (shift !== 3'b000) begin $display("FAIL mod_shift_rel got=%b want=000", shift); n_err++; end
        n_vec++;
        if (reset_key !== 3'b000) begin $display("FAIL mod_rkey_rel got=%b want=000", reset_key); n_err++; end
        n_vec++;
        key(8'hE0); key(8'h14); key(8'h58); key(8'h07);
        if (shift !== 3'b110) begin $display("FAIL rctrl_caps got=%b want=110", shift); n_err++; end
        n_vec++;
        if (reset_key !== 3'b010) begin $display("FAIL f12 got=%b want=010", reset_key); n_err++; end
        n_vec++;
        key(8'hE0); key(8'hF0); key(8'h14); key(8'hF0); key(8'h58); key(8'hF0); key(8'h07);
        if ({shift, reset_key} !== 6'b000000) begin
            $display("FAIL mod_clear got=%b%b want=000000", shift, reset_key); n_err++;
        end
        n_vec++;
        $display("modifiers done: shift=%b reset_key=%b", shift, reset_key);
    endtask

    task automatic test_pause_skip();
        key(8'hE1); key(8'h14); key(8'h77); key(8'hE1);
        key(8'hF0); key(8'h14); key(8'hF0); key(8'h77);
        if (shift !== 3'b000) begin $display("FAIL pause_skip got=%b want=000", shift); n_err++; end
        n_vec++;
        addr = 8'h10;
        key(8'h1C);
        if (odata !== 8'h02) begin $display("FAIL after_pause got=%02h want=02", odata); n_err++; end
        n_vec++;
        key(8'hF0); key(8'h1C);
        $display("pause sequence done: shift=%b odata=%02h", shift, odata);
    endtask

    task automatic test_glitch_timeout();
        addr = 8'h80;
        ps2_dat = 1'b0;
        ps2_clk = 1'b0;
        cycles(8);
        ps2_clk = 1'b1;
        cycles(40);
        ps2_dat = 1'b1;
        cycles(20);
        key(8'h29);
        if (odata !== 8'h80) begin $display("FAIL glitch_space got=%02h want=80", odata); n_err++; end
        n_vec++;
        send_bits({1'b1, 1'b1, 8'hF0, 1'b0}, 6);
        cycles(TO + 200);
        key(8'hF0); key(8'h29);
        if (odata !== 8'h00) begin $display("FAIL timeout_break got=%02h want=00", odata); n_err++; end
        n_vec++;
        $display("glitch/timeout done: odata=%02h", odata);
    endtask

    task automatic test_back_to_back();
        addr = 8'h90;
        key(8'h1C); key(8'h29);
        if (odata !== 8'h82) begin $display("FAIL hold_two got=%02h want=82", odata); n_err++; end
        n_vec++;
        pulse_reset();
        if (odata !== 8'h00) begin $display("FAIL reset_clear got=%02h want=00", odata); n_err++; end
        n_vec++;
        cycles(4);
        if (odata !== 8'h00) begin $display("FAIL reset_hold got=%02h want=00", odata); n_err++; end
        n_vec++;
        $display("hold + reset done: odata=%02h", odata);
    endtask

    task automatic test_prefix_reset();
        addr = 8'h01;
        key(8'hE0);
        pulse_reset();
        cycles(40);
        key(8'h75);
        if (odata !== 8'h00) begin $display("FAIL prefix_reset got=%02h want=00", odata); n_err++; end
        n_vec++;
        key(8'hE0); key(8'h75);
        if (odata !== 8'h20) begin $display("FAIL after_prefix_reset got=%02h want=20", odata); n_err++; end
        n_vec++;
        $display("prefix reset done: odata=%02h", odata);
    endtask

    initial begin
        cycles(4);
        reset = 1'b0;
        cycles(40);
        test_reset();
        test_make_break();
        test_extended();
        test_parity();
        test_modifiers();
        test_pause_skip();
        test_glitch_timeout();
        test_back_to_back();
        test_prefix_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
